quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 pCNT_BITS, default 16: width of the position counter.
REQ-002 pPRESC_BITS, default 6: sample prescaler width; one sample tick every 2^pPRESC_BITS clocks; minimum 1.
REQ-003 iCLK  input  1  system clock; all logic rising-edge.
REQ-004 iRESETn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 iENC_A  input  1  encoder channel A; asynchronous to iCLK.
REQ-006 iENC_B  input  1  encoder channel B; asynchronous to iCLK.
REQ-007 iENABLE  input  1  1 = counting permitted; 0 = state tracked, count frozen.
REQ-008 iCLEAR  input  1  single-cycle request: zero count, clear error.
REQ-009 oCOUNT  output  pCNT_BITS  signed two's-complement position, x4 decoding.
REQ-010 oSTEP_INC  output  1  one-cycle pulse per accepted forward step.
REQ-011 oSTEP_DEC  output  1  one-cycle pulse per accepted reverse step.
REQ-012 oDIR  output  1  direction of last accepted step; 1 = forward.
REQ-013 oERROR  output  1  sticky; set on illegal transition (A and B both changed).

Function
REQ-014 A and B SHALL each pass a 2-flop synchronizer before any other use.
REQ-015 Prescaler SHALL free-run from 0; tick asserted in the cycle its value is 0.
REQ-016 On each tick, synchronized {A,B} SHALL be stored in sample register S.
REQ-017 Candidate state SHALL be accepted only when synchronized {A,B} at a tick equals S (stable for two consecutive ticks).
REQ-018 Accepted state SHALL be decoded against tracked state T, Gray order 00->01->11->10->00.
REQ-019 Forward neighbour SHALL increment oCOUNT by 1; reverse neighbour SHALL decrement it by 1; T updated in both cases.
REQ-020 Candidate equal to T SHALL cause no action.
REQ-021 Candidate differing in both bits SHALL set oERROR, update T, leave oCOUNT unchanged, and produce no step pulse.
REQ-022 oCOUNT SHALL wrap modulo 2^pCNT_BITS: max positive +1 -> most negative; most negative -1 -> max positive.
REQ-023 oCOUNT, oSTEP_*, oDIR and oERROR SHALL be registered; update visible one cycle after the accepting tick.
REQ-024 With iENABLE=0, T SHALL still update, but oCOUNT, oDIR and the step pulses SHALL not change; oERROR SHALL still set.
REQ-025 iCLEAR SHALL zero oCOUNT and clear oERROR next cycle; priority over a same-cycle step or error, which is discarded.
REQ-026 The first accepted state after reset SHALL initialize T without counting or flagging error (init flag).

Reset
REQ-027 While iRESETn=0 at a clock edge: oCOUNT=0, oSTEP_INC=0, oSTEP_DEC=0, oDIR=0, oERROR=0, prescaler=0, init flag set; synchronizers, S and T cleared.
REQ-028 Reset asserted mid-operation SHALL discard any in-progress transition; the next accepted state re-initializes T per REQ-026.

Structure
REQ-029 Gray state encoding constants and the step/error decode codes SHALL live in a shared package, quad_pkg.
REQ-030 The synchronizer-plus-stability filter SHALL be one sub-module, quad_input_filter, instantiated once for the 2-bit {A,B} bus.
REQ-031 The block SHALL be instantiable per encoder; a multi-encoder wrapper is out of scope.

Verification
REQ-032 pPRESC_BITS=2, reset, hold AB=00, then 4 forward steps (01,11,10,00), each held 16 clocks -> oCOUNT=4, four oSTEP_INC pulses, oDIR=1, oERROR=0.
REQ-033 From count 0, 3 reverse steps -> oCOUNT=16'hFFFD; then 3 forward steps -> oCOUNT=0.
REQ-034 AB 00->11 in one step, held 16 clocks -> oERROR=1, oCOUNT unchanged; iCLEAR pulse -> oERROR=0, oCOUNT=0 next cycle.
REQ-035 1-clock glitch on A between ticks, and a 1-tick pulse -> no count change, no step pulse.
REQ-036 pCNT_BITS=4, count at 7, one forward step -> oCOUNT=4'h8 (-8); iCLEAR on the same cycle as an accepted step -> oCOUNT=0, no step pulse.
REQ-037 Reset applied with AB=11, released -> first accepted state 11 gives oCOUNT=0 and oERROR=0; iENABLE=0 during 2 steps -> count frozen, and the next enabled step counts from the new T.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: Gray-cycle state constants,
// step classification codes and the neighbour decode used against tracked state.
package quad_pkg;

   localparam int unsigned AB_W = 2;

   localparam logic [AB_W-1:0] GRAY_0 = 2'b00;
   localparam logic [AB_W-1:0] GRAY_1 = 2'b01;
   localparam logic [AB_W-1:0] GRAY_2 = 2'b11;
   localparam logic [AB_W-1:0] GRAY_3 = 2'b10;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   function automatic logic [AB_W-1:0] gray_next(input logic [AB_W-1:0] s);
      logic [AB_W-1:0] n;
      case (s)
         GRAY_0:  n = GRAY_1;
         GRAY_1:  n = GRAY_2;
         GRAY_2:  n = GRAY_3;
         default: n = GRAY_0;
      endcase
      return n;
   endfunction

   function automatic logic [AB_W-1:0] gray_prev(input logic [AB_W-1:0] s);
      logic [AB_W-1:0] p;
      case (s)
         GRAY_0:  p = GRAY_3;
         GRAY_1:  p = GRAY_0;
         GRAY_2:  p = GRAY_1;
         default: p = GRAY_2;
      endcase
      return p;
   endfunction

   // Classify a candidate against tracked state; a two-bit change is illegal.
   function automatic step_e quad_decode(input logic [AB_W-1:0] t, input logic [AB_W-1:0] c);
      step_e r;
      r = STEP_ERR;
      if (c == t)                 r = STEP_NONE;
      else if (c == gray_next(t)) r = STEP_FWD;
      else if (c == gray_prev(t)) r = STEP_REV;
      return r;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchronizes the {A,B} encoder bus and accepts a state only when it has been
// sampled identically on two consecutive prescaler ticks.
module quad_input_filter
   import quad_pkg::*;
#(
   parameter int unsigned pPRESC_BITS = 6
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [AB_W-1:0] i_ab,
   output logic            o_accept_c,
   output logic [AB_W-1:0] o_state_c
);

   logic [AB_W-1:0]        r_sync1;
   logic [AB_W-1:0]        r_sync2;
   logic [AB_W-1:0]        r_sample;
   logic                   r_sample_vld;
   logic [pPRESC_BITS-1:0] r_presc;
   logic                   w_tick;

   assign w_tick = (r_presc == '0);

   // The sample register holds stale reset data until the first tick has loaded it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_sample     <= '0;
         r_sample_vld <= 1'b0;
         r_presc      <= '0;
      end else begin
         r_sync1 <= i_ab;
         r_sync2 <= r_sync1;
         r_presc <= r_presc + pPRESC_BITS'(1);
         if (w_tick) begin
            r_sample     <= r_sync2;
            r_sample_vld <= 1'b1;
         end
      end
   end

   assign o_accept_c = w_tick && r_sample_vld && (r_sync2 == r_sample);
   assign o_state_c  = r_sync2;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered {A,B} states are decoded against the tracked
// state to drive a wrapping signed position count, step pulses and a sticky error.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned pCNT_BITS   = 16,
   parameter int unsigned pPRESC_BITS = 6
) (
   input  logic                        iCLK,
   input  logic                        iRESETn,
   input  logic                        iENC_A,
   input  logic                        iENC_B,
   input  logic                        iENABLE,
   input  logic                        iCLEAR,
   output logic signed [pCNT_BITS-1:0] oCOUNT,
   output logic                        oSTEP_INC,
   output logic                        oSTEP_DEC,
   output logic                        oDIR,
   output logic                        oERROR
);

   logic                 w_accept;
   logic [AB_W-1:0]      w_cand;
   step_e                w_step;
   logic                 w_live;
   logic                 w_fwd;
   logic                 w_rev;
   logic                 w_err;

   logic [AB_W-1:0]      r_track;
   logic                 r_init;
   logic [pCNT_BITS-1:0] r_count;
   logic                 r_inc;
   logic                 r_dec;
   logic                 r_dir;
   logic                 r_error;

   quad_input_filter #(
      .pPRESC_BITS(pPRESC_BITS)
   ) u_filter (
      .i_clk      (iCLK),
      .i_rst_n    (iRESETn),
      .i_ab       ({iENC_A, iENC_B}),
      .o_accept_c (w_accept),
      .o_state_c  (w_cand)
   );

   assign w_step = quad_decode(r_track, w_cand);

   // A clear request swallows any step or error accepted in the same cycle.
   always_comb begin
      w_live = w_accept && !r_init && !iCLEAR;
      w_fwd  = w_live && iENABLE && (w_step == STEP_FWD);
      w_rev  = w_live && iENABLE && (w_step == STEP_REV);
      w_err  = w_live && (w_step == STEP_ERR);
   end

   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         r_track <= '0;
         r_init  <= 1'b1;
         r_count <= '0;
         r_inc   <= 1'b0;
         r_dec   <= 1'b0;
         r_dir   <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_inc <= w_fwd;
         r_dec <= w_rev;
         if (w_accept) begin
            r_track <= w_cand;
            r_init  <= 1'b0;
         end
         if (iCLEAR) begin
            r_count <= '0;
            r_error <= 1'b0;
         end else begin
            if (w_fwd) begin
               r_count <= r_count + pCNT_BITS'(1);
               r_dir   <= 1'b1;
            end
            if (w_rev) begin
               r_count <= r_count - pCNT_BITS'(1);
               r_dir   <= 1'b0;
            end
            if (w_err) r_error <= 1'b1;
         end
      end
   end

   assign oCOUNT    = r_count;
   assign oSTEP_INC = r_inc;
   assign oSTEP_DEC = r_dec;
   assign oDIR      = r_dir;
   assign oERROR    = r_error;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: directed encoder sequences push expected
// step events; per-instance monitors pop and compare whenever a step pulse appears.
module tb_quad_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, en16, clr16;
   logic [1:0]  ab16;
   logic [15:0] cnt16;
   logic        inc16, dec16, dir16, err16;

   logic        rst4, en4, clr4;
   logic [1:0]  ab4;
   logic [3:0]  cnt4;
   logic        inc4, dec4, dir4, err4;

   quad_decoder #(.pCNT_BITS(16), .pPRESC_BITS(2)) u_dut16 (
      .iCLK(clk), .iRESETn(rst16), .iENC_A(ab16[1]), .iENC_B(ab16[0]),
      .iENABLE(en16), .iCLEAR(clr16), .oCOUNT(cnt16), .oSTEP_INC(inc16),
      .oSTEP_DEC(dec16), .oDIR(dir16), .oERROR(err16));

   quad_decoder #(.pCNT_BITS(4), .pPRESC_BITS(2)) u_dut4 (
      .iCLK(clk), .iRESETn(rst4), .iENC_A(ab4[1]), .iENC_B(ab4[0]),
      .iENABLE(en4), .iCLEAR(clr4), .oCOUNT(cnt4), .oSTEP_INC(inc4),
      .oSTEP_DEC(dec4), .oDIR(dir4), .oERROR(err4));

   typedef struct {
      logic        inc;
      logic [15:0] cnt;
   } exp_t;

   exp_t q16[$];
   exp_t q4[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ecnt4    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Index of the next clock edge the 4-bit instance processes out of reset.
   always @(posedge clk) begin
      if (!rst4) ecnt4 <= 0;
      else       ecnt4 <= ecnt4 + 1;
   end

   always @(negedge clk) begin
      if (rst16 && (inc16 || dec16)) begin
         if (q16.size() == 0) begin
            check("dut16 unexpected step", {30'b0, inc16, dec16}, 32'd0);
         end else begin
            exp_t e;
            e = q16.pop_front();
            check("dut16 step kind", {30'b0, inc16, dec16}, e.inc ? 32'd2 : 32'd1);
            check("dut16 step count", cnt16, e.cnt);
            check("dut16 step dir", dir16, e.inc);
         end
      end
   end

   always @(negedge clk) begin
      if (rst4 && (inc4 || dec4)) begin
         if (q4.size() == 0) begin
            check("dut4 unexpected step", {30'b0, inc4, dec4}, 32'd0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("dut4 step kind", {30'b0, inc4, dec4}, e.inc ? 32'd2 : 32'd1);
            check("dut4 step count", cnt4, e.cnt[3:0]);
            check("dut4 step dir", dir4, e.inc);
         end
      end
   end

   // kind: 0 = no step expected, 1 = forward, 2 = reverse; c = count after the step.
   task automatic step16(input logic [1:0] ab, input int kind, input logic [15:0] c);
      @(negedge clk);
      ab16 = ab;
      if (kind == 1)      q16.push_back('{1'b1, c});
      else if (kind == 2) q16.push_back('{1'b0, c});
      repeat (15) @(negedge clk);
   endtask

   task automatic step4(input logic [1:0] ab, input int kind, input logic [15:0] c);
      @(negedge clk);
      ab4 = ab;
      if (kind == 1)      q4.push_back('{1'b1, c});
      else if (kind == 2) q4.push_back('{1'b0, c});
      repeat (15) @(negedge clk);
   endtask

   task automatic pulse_clr16();
      @(negedge clk);
      clr16 = 1'b1;
      @(negedge clk);
      clr16 = 1'b0;
   endtask

   initial begin
      int n, e, a;
      rst16 = 1'b0; en16 = 1'b1; clr16 = 1'b0; ab16 = 2'b00;
      rst4  = 1'b0; en4  = 1'b1; clr4  = 1'b0; ab4  = 2'b00;
      repeat (3) @(negedge clk);
      check("reset count", cnt16, 32'd0);
      check("reset inc", inc16, 32'd0);
      check("reset dec", dec16, 32'd0);
      check("reset dir", dir16, 32'd0);
      check("reset error", err16, 32'd0);
      check("reset count4", cnt4, 32'd0);

      rst16 = 1'b1;
      repeat (16) @(negedge clk);
      check("init count", cnt16, 32'd0);
      check("init error", err16, 32'd0);

      // Four forward steps
      step16(2'b01, 1, 16'd1);
      step16(2'b11, 1, 16'd2);
      step16(2'b10, 1, 16'd3);
      step16(2'b00, 1, 16'd4);
      check("fwd4 count", cnt16, 32'd4);
      check("fwd4 dir", dir16, 32'd1);
      check("fwd4 error", err16, 32'd0);
      check("fwd4 pending", q16.size(), 32'd0);

      // Reverse below zero and back
      pulse_clr16();
      check("clear count", cnt16, 32'd0);
      step16(2'b10, 2, 16'hFFFF);
      step16(2'b11, 2, 16'hFFFE);
      step16(2'b01, 2, 16'hFFFD);
      check("rev3 count", cnt16, 32'h0000FFFD);
      check("rev3 dir", dir16, 32'd0);
      step16(2'b11, 1, 16'hFFFE);
      step16(2'b10, 1, 16'hFFFF);
      step16(2'b00, 1, 16'h0000);
      check("back to zero", cnt16, 32'd0);

      // Illegal double-bit transition
      step16(2'b01, 1, 16'd1);
      step16(2'b11, 1, 16'd2);
      step16(2'b10, 1, 16'd3);
      step16(2'b00, 1, 16'd4);
      step16(2'b11, 0, 16'd0);
      check("illegal error", err16, 32'd1);
      check("illegal count", cnt16, 32'd4);
      pulse_clr16();
      check("clear error", err16, 32'd0);
      check("clear count2", cnt16, 32'd0);

      // Short disturbances must be filtered
      @(negedge clk); ab16 = 2'b01;
      @(negedge clk); ab16 = 2'b11;
      repeat (16) @(negedge clk);
      check("glitch count", cnt16, 32'd0);
      @(negedge clk); ab16 = 2'b01;
      repeat (4) @(negedge clk);
      ab16 = 2'b11;
      repeat (16) @(negedge clk);
      check("tick pulse count", cnt16, 32'd0);
      check("filter pending", q16.size(), 32'd0);

      // Mid-transition reset with AB=11, then re-init and disabled tracking
      step16(2'b10, 1, 16'd1);
      @(negedge clk); ab16 = 2'b00;
      repeat (4) @(negedge clk);
      rst16 = 1'b0; ab16 = 2'b11;
      repeat (3) @(negedge clk);
      check("midreset count", cnt16, 32'd0);
      check("midreset dir", dir16, 32'd0);
      check("midreset inc", inc16, 32'd0);
      rst16 = 1'b1;
      repeat (16) @(negedge clk);
      check("reinit count", cnt16, 32'd0);
      check("reinit error", err16, 32'd0);
      en16 = 1'b0;
      step16(2'b10, 0, 16'd0);
      step16(2'b00, 0, 16'd0);
      check("disabled count", cnt16, 32'd0);
      check("disabled dir", dir16, 32'd0);
      en16 = 1'b1;
      step16(2'b01, 1, 16'd1);
      check("enabled count", cnt16, 32'd1);
      check("enabled dir", dir16, 32'd1);
      en16 = 1'b0;
      step16(2'b10, 0, 16'd0);
      check("disabled error", err16, 32'd1);
      check("disabled err count", cnt16, 32'd1);
      en16 = 1'b1;
      check("dut16 pending", q16.size(), 32'd0);

      // 4-bit counter wrap and clear colliding with a step
      @(negedge clk); rst4 = 1'b1;
      repeat (16) @(negedge clk);
      step4(2'b01, 1, 16'd1);
      step4(2'b11, 1, 16'd2);
      step4(2'b10, 1, 16'd3);
      step4(2'b00, 1, 16'd4);
      step4(2'b01, 1, 16'd5);
      step4(2'b11, 1, 16'd6);
      step4(2'b10, 1, 16'd7);
      check("cnt4 at 7", cnt4, 32'd7);
      step4(2'b00, 1, 16'd8);
      check("cnt4 wrap", cnt4, 32'h8);

      @(negedge clk);
      ab4 = 2'b01;
      n = ecnt4;
      e = ((n + 5) / 4) * 4;
      a = e + 4;
      for (int k = 0; k < 20 && ecnt4 != a; k++) @(negedge clk);
      clr4 = 1'b1;
      @(negedge clk);
      clr4 = 1'b0;
      check("clear+step count", cnt4, 32'd0);
      check("clear+step inc", inc4, 32'd0);
      repeat (16) @(negedge clk);
      check("clear+step settled", cnt4, 32'd0);
      step4(2'b00, 2, 16'hF);
      check("cnt4 under", cnt4, 32'hF);
      check("dut4 pending", q4.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
